// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the AXI read arbiter between icache and dcache.
package axi_rd_arbiter_pkg;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam logic [3:0] ID_ICACHE    = 4'd0;
  localparam logic [3:0] ID_DCACHE    = 4'd1;

  typedef enum logic {
    A_IDLE = 1'b0,
    A_SEND = 1'b1
  } ar_state_e;

  // Line bursts are always word-sized; single beats carry their own size.
  function automatic logic [2:0] rd_arsize(input logic [2:0] rd_type);
    return (rd_type == RD_TYPE_LINE) ? SIZE_WORD : {1'b0, rd_type[1:0]};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Cache-side request/return signals, write-hazard inputs and the AXI AR/R channel.
interface axi_rd_arbiter_if;

  logic        icache_rd_req;
  logic [2:0]  icache_rd_type;
  logic [31:0] icache_rd_addr;
  logic        icache_rd_rdy;
  logic        icache_ret_valid;
  logic        icache_ret_last;
  logic [31:0] icache_ret_data;

  logic        dcache_rd_req;
  logic [2:0]  dcache_rd_type;
  logic [31:0] dcache_rd_addr;
  logic        dcache_rd_rdy;
  logic        dcache_ret_valid;
  logic        dcache_ret_last;
  logic [31:0] dcache_ret_data;

  logic        wr_pending;
  logic [31:0] wr_pend_addr;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        rd_err;

  modport master (
    input  icache_rd_req, icache_rd_type, icache_rd_addr,
    output icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    input  dcache_rd_req, dcache_rd_type, dcache_rd_addr,
    output dcache_rd_rdy, dcache_ret_valid, dcache_ret_last, dcache_ret_data,
    input  wr_pending, wr_pend_addr,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready, rd_err
  );

  modport slave (
    output icache_rd_req, icache_rd_type, icache_rd_addr,
    input  icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    output dcache_rd_req, dcache_rd_type, dcache_rd_addr,
    input  dcache_rd_rdy, dcache_ret_valid, dcache_ret_last, dcache_ret_data,
    output wr_pending, wr_pend_addr,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready, rd_err
  );

endinterface

// File: rtl/axi_rd_track.sv
// Per-ID read tracker: outstanding flag, expected burst length, beat count and protocol checks.
module axi_rd_track (
  input  logic       aclk,
  input  logic       reset,
  input  logic       i_set,
  input  logic [7:0] i_arlen,
  input  logic       i_beat,
  input  logic       i_rlast,
  input  logic       i_rresp_err,
  output logic       o_out,
  output logic       o_ret_valid,
  output logic       o_ret_last,
  output logic       o_err
);

  logic       r_out;
  logic [7:0] r_arlen;
  logic [7:0] r_cnt;
  logic       w_hit;
  logic       w_len_err;

  assign w_hit       = i_beat & r_out;
  assign w_len_err   = i_rlast ? (r_cnt != r_arlen) : (r_cnt == r_arlen);
  assign o_out       = r_out;
  assign o_ret_valid = w_hit;
  assign o_ret_last  = w_hit & i_rlast;
  // A beat for an idle ID is dropped and flagged; delivered beats are checked for length and response.
  assign o_err       = (i_beat & ~r_out) | (w_hit & (i_rresp_err | w_len_err));

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_out   <= 1'b0;
      r_arlen <= 8'd0;
      r_cnt   <= 8'd0;
    end else if (i_set) begin
      r_out   <= 1'b1;
      r_arlen <= i_arlen;
      r_cnt   <= 8'd0;
    end else if (w_hit) begin
      if (i_rlast) begin
        r_out <= 1'b0;
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between icache (index 0) and dcache (index 1),
// one outstanding read per requester, with write-hazard blocking and R-path checks.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 4,
  parameter logic [3:0]  ICACHE_ID  = ID_ICACHE,
  parameter logic [3:0]  DCACHE_ID  = ID_DCACHE
) (
  input  logic             aclk,
  input  logic             reset,
  axi_rd_arbiter_if.master bus
);

  localparam int unsigned LSB      = $clog2(LINE_BEATS * 4);
  localparam logic [7:0]  LINE_LEN = 8'(LINE_BEATS - 1);

  ar_state_e   r_state;
  ar_state_e   w_state_next;
  logic        r_last_grant_d;
  logic [3:0]  r_arid;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic        r_rd_err;

  logic [1:0]  w_req, w_haz, w_elig, w_grant, w_out, w_beat, w_set;
  logic [1:0]  w_ret_valid, w_ret_last, w_err;
  logic [31:0] w_addr [2];
  logic [2:0]  w_type [2];
  logic [3:0]  w_id   [2];
  logic        w_sel;
  logic        w_ar_done;
  logic        w_bad_id;
  logic        w_unused_bits;

  assign w_req     = {bus.dcache_rd_req, bus.icache_rd_req};
  assign w_addr[0] = bus.icache_rd_addr;
  assign w_addr[1] = bus.dcache_rd_addr;
  assign w_type[0] = bus.icache_rd_type;
  assign w_type[1] = bus.dcache_rd_type;
  assign w_id[0]   = ICACHE_ID;
  assign w_id[1]   = DCACHE_ID;

  assign w_ar_done     = (r_state == A_SEND) & bus.arready;
  assign w_bad_id      = bus.rvalid & (bus.rid != ICACHE_ID) & (bus.rid != DCACHE_ID);
  assign w_unused_bits = &{1'b0, bus.wr_pend_addr[LSB-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_haz[gi]  = bus.wr_pending &
                          (bus.wr_pend_addr[31:LSB] == w_addr[gi][31:LSB]);
      assign w_elig[gi] = w_req[gi] & ~w_out[gi] & ~w_haz[gi];
      assign w_beat[gi] = bus.rvalid & (bus.rid == w_id[gi]);
      assign w_set[gi]  = w_ar_done & (r_arid == w_id[gi]);

      axi_rd_track u_track (
        .aclk        (aclk),
        .reset       (reset),
        .i_set       (w_set[gi]),
        .i_arlen     (r_arlen),
        .i_beat      (w_beat[gi]),
        .i_rlast     (bus.rlast),
        .i_rresp_err (|bus.rresp),
        .o_out       (w_out[gi]),
        .o_ret_valid (w_ret_valid[gi]),
        .o_ret_last  (w_ret_last[gi]),
        .o_err       (w_err[gi])
      );
    end
  endgenerate

  // On a tie the requester that did not win last time goes first.
  assign w_grant[1] = w_elig[1] & (~w_elig[0] | ~r_last_grant_d);
  assign w_grant[0] = w_elig[0] & ~w_grant[1];
  assign w_sel      = w_grant[1];

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= A_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      A_IDLE:  if (|w_grant) w_state_next = A_SEND;
      A_SEND:  if (bus.arready) w_state_next = A_IDLE;
      default: w_state_next = A_IDLE;
    endcase
  end

  always_comb begin
    bus.arvalid          = (r_state == A_SEND);
    bus.icache_rd_rdy    = (r_state == A_IDLE) & w_grant[0];
    bus.dcache_rd_rdy    = (r_state == A_IDLE) & w_grant[1];
    bus.arid             = r_arid;
    bus.araddr           = r_araddr;
    bus.arlen            = r_arlen;
    bus.arsize           = r_arsize;
    bus.arburst          = BURST_INCR;
    bus.arlock           = 2'b00;
    bus.arcache          = 4'b0000;
    bus.arprot           = 3'b000;
    bus.rready           = 1'b1;
    bus.rd_err           = r_rd_err;
    bus.icache_ret_valid = w_ret_valid[0];
    bus.icache_ret_last  = w_ret_last[0];
    bus.icache_ret_data  = bus.rdata;
    bus.dcache_ret_valid = w_ret_valid[1];
    bus.dcache_ret_last  = w_ret_last[1];
    bus.dcache_ret_data  = bus.rdata;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_arid         <= 4'd0;
      r_araddr       <= 32'd0;
      r_arlen        <= 8'd0;
      r_arsize       <= SIZE_WORD;
      r_last_grant_d <= 1'b0;
    end else if ((r_state == A_IDLE) && (|w_grant)) begin
      r_arid         <= w_id[w_sel];
      r_araddr       <= w_addr[w_sel];
      r_arlen        <= (w_type[w_sel] == RD_TYPE_LINE) ? LINE_LEN : 8'd0;
      r_arsize       <= rd_arsize(w_type[w_sel]);
      r_last_grant_d <= w_sel;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_rd_err <= 1'b0;
    end else if (w_bad_id || (|w_err)) begin
      r_rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grants, bursts, hazards, interleaving and error flagging.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter #(
    .LINE_BEATS (4),
    .ICACHE_ID  (4'd0),
    .DCACHE_ID  (4'd1)
  ) dut (
    .aclk  (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    $display("check %-14s observed=%0h expected=%0h", tag, obs, req);
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                      input logic [1:0] resp);
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rdata  = data;
    bus.rlast  = last;
    bus.rresp  = resp;
  endtask

  task automatic r_idle();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
  endtask

  initial begin
    reset              = 1'b1;
    bus.icache_rd_req  = 1'b0;
    bus.icache_rd_type = 3'b010;
    bus.icache_rd_addr = 32'h0;
    bus.dcache_rd_req  = 1'b0;
    bus.dcache_rd_type = 3'b010;
    bus.dcache_rd_addr = 32'h0;
    bus.wr_pending     = 1'b0;
    bus.wr_pend_addr   = 32'h0;
    bus.arready        = 1'b0;
    bus.rid            = 4'd0;
    bus.rdata          = 32'h0;
    r_idle();
    step();
    step();
    reset = 1'b0;

    // Reset state
    settle();
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_arid", bus.arid, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arlen", bus.arlen, 0);
    chk("rst_arsize", bus.arsize, 3'b010);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_irdy", bus.icache_rd_rdy, 0);
    chk("rst_dret", bus.dcache_ret_valid, 0);
    chk("rst_rready", bus.rready, 1);
    chk("rst_arburst", bus.arburst, 2'b01);

    // Single dcache word read at 0x1000, arready together with arvalid
    step();
    bus.dcache_rd_req  = 1'b1;
    bus.dcache_rd_type = 3'b010;
    bus.dcache_rd_addr = 32'h1000;
    settle();
    chk("t1_drdy", bus.dcache_rd_rdy, 1);
    chk("t1_irdy", bus.icache_rd_rdy, 0);
    step();
    bus.dcache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    settle();
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_arid", bus.arid, 1);
    chk("t1_araddr", bus.araddr, 32'h1000);
    chk("t1_arlen", bus.arlen, 0);
    chk("t1_arsize", bus.arsize, 2);
    step();
    bus.arready = 1'b0;
    beat(4'd1, 32'hDEADBEEF, 1'b1, 2'b00);
    settle();
    chk("t1_dret", bus.dcache_ret_valid, 1);
    chk("t1_dlast", bus.dcache_ret_last, 1);
    chk("t1_ddata", bus.dcache_ret_data, 32'hDEADBEEF);
    chk("t1_iret", bus.icache_ret_valid, 0);
    chk("t1_arvalid_lo", bus.arvalid, 0);
    step();
    r_idle();
    settle();
    chk("t1_rd_err", bus.rd_err, 0);

    // icache line read at 0x2000: four beats, last on the fourth
    step();
    bus.icache_rd_req  = 1'b1;
    bus.icache_rd_type = 3'b100;
    bus.icache_rd_addr = 32'h2000;
    settle();
    chk("t2_irdy", bus.icache_rd_rdy, 1);
    step();
    bus.icache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    settle();
    chk("t2_arid", bus.arid, 0);
    chk("t2_araddr", bus.araddr, 32'h2000);
    chk("t2_arlen", bus.arlen, 3);
    chk("t2_arsize", bus.arsize, 2);
    step();
    bus.arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      beat(4'd0, 32'h100 + b, (b == 3), 2'b00);
      settle();
      chk("t2_iret", bus.icache_ret_valid, 1);
      chk("t2_ilast", bus.icache_ret_last, (b == 3) ? 1 : 0);
      chk("t2_idata", bus.icache_ret_data, 32'h100 + b);
      chk("t2_dret", bus.dcache_ret_valid, 0);
      step();
    end
    r_idle();
    settle();
    chk("t2_rd_err", bus.rd_err, 0);

    // Both requesting: grant order D, I, D, I; a repeat grant waits for rlast
    step();
    bus.icache_rd_req  = 1'b1;
    bus.icache_rd_type = 3'b010;
    bus.icache_rd_addr = 32'h5000;
    bus.dcache_rd_req  = 1'b1;
    bus.dcache_rd_type = 3'b010;
    bus.dcache_rd_addr = 32'h6000;
    settle();
    chk("t3_g1_drdy", bus.dcache_rd_rdy, 1);
    chk("t3_g1_irdy", bus.icache_rd_rdy, 0);
    step();
    bus.arready = 1'b1;
    settle();
    chk("t3_g1_arid", bus.arid, 1);
    chk("t3_send_irdy", bus.icache_rd_rdy, 0);
    step();
    bus.arready = 1'b0;
    settle();
    chk("t3_g2_irdy", bus.icache_rd_rdy, 1);
    chk("t3_g2_drdy", bus.dcache_rd_rdy, 0);
    step();
    bus.arready = 1'b1;
    settle();
    chk("t3_g2_arid", bus.arid, 0);
    step();
    bus.arready = 1'b0;
    settle();
    chk("t3_wait_irdy", bus.icache_rd_rdy, 0);
    chk("t3_wait_drdy", bus.dcache_rd_rdy, 0);
    step();
    beat(4'd1, 32'h66, 1'b1, 2'b00);
    settle();
    chk("t3_dret", bus.dcache_ret_valid, 1);
    chk("t3_last_drdy", bus.dcache_rd_rdy, 0);
    step();
    r_idle();
    settle();
    chk("t3_g3_drdy", bus.dcache_rd_rdy, 1);
    step();
    bus.arready = 1'b1;
    settle();
    chk("t3_g3_arid", bus.arid, 1);
    step();
    bus.arready = 1'b0;
    beat(4'd0, 32'h55, 1'b1, 2'b00);
    settle();
    chk("t3_iret", bus.icache_ret_valid, 1);
    chk("t3_iret_drdy", bus.dcache_rd_rdy, 0);
    step();
    r_idle();
    settle();
    chk("t3_g4_irdy", bus.icache_rd_rdy, 1);
    step();
    bus.icache_rd_req = 1'b0;
    bus.dcache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    settle();
    chk("t3_g4_arid", bus.arid, 0);
    step();
    bus.arready = 1'b0;
    beat(4'd1, 32'h61, 1'b1, 2'b00);
    settle();
    chk("t3_drain_d", bus.dcache_ret_valid, 1);
    step();
    beat(4'd0, 32'h51, 1'b1, 2'b00);
    settle();
    chk("t3_drain_i", bus.icache_ret_valid, 1);
    step();
    r_idle();
    settle();
    chk("t3_rd_err", bus.rd_err, 0);

    // Write hazard blocks dcache 0x3008 against pending write 0x3004; icache 0x4000 proceeds
    step();
    bus.wr_pending     = 1'b1;
    bus.wr_pend_addr   = 32'h3004;
    bus.dcache_rd_req  = 1'b1;
    bus.dcache_rd_type = 3'b010;
    bus.dcache_rd_addr = 32'h3008;
    bus.icache_rd_req  = 1'b1;
    bus.icache_rd_type = 3'b010;
    bus.icache_rd_addr = 32'h4000;
    settle();
    chk("t4_drdy_blk", bus.dcache_rd_rdy, 0);
    chk("t4_irdy", bus.icache_rd_rdy, 1);
    step();
    bus.icache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    settle();
    chk("t4_iaddr", bus.araddr, 32'h4000);
    step();
    bus.arready = 1'b0;
    settle();
    chk("t4_drdy_blk2", bus.dcache_rd_rdy, 0);
    step();
    settle();
    chk("t4_drdy_blk3", bus.dcache_rd_rdy, 0);
    step();
    bus.wr_pending = 1'b0;
    settle();
    chk("t4_drdy_free", bus.dcache_rd_rdy, 1);
    step();
    bus.dcache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    settle();
    chk("t4_daddr", bus.araddr, 32'h3008);
    chk("t4_darid", bus.arid, 1);
    step();
    bus.arready = 1'b0;
    beat(4'd0, 32'h44, 1'b1, 2'b00);
    settle();
    chk("t4_idata", bus.icache_ret_data, 32'h44);
    chk("t4_iret", bus.icache_ret_valid, 1);
    step();
    beat(4'd1, 32'h33, 1'b1, 2'b00);
    settle();
    chk("t4_dret", bus.dcache_ret_valid, 1);
    step();
    r_idle();

    // Interleaved R beats: dcache line and icache word share the R channel
    bus.dcache_rd_req  = 1'b1;
    bus.dcache_rd_type = 3'b100;
    bus.dcache_rd_addr = 32'h7000;
    bus.icache_rd_req  = 1'b1;
    bus.icache_rd_type = 3'b010;
    bus.icache_rd_addr = 32'h8000;
    settle();
    chk("t5_irdy", bus.icache_rd_rdy, 1);
    step();
    bus.icache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    step();
    settle();
    chk("t5_drdy", bus.dcache_rd_rdy, 1);
    step();
    bus.dcache_rd_req = 1'b0;
    settle();
    chk("t5_darlen", bus.arlen, 3);
    step();
    bus.arready = 1'b0;
    beat(4'd1, 32'hA0, 1'b0, 2'b00);
    settle();
    chk("t5_d0_dret", bus.dcache_ret_valid, 1);
    chk("t5_d0_iret", bus.icache_ret_valid, 0);
    chk("t5_d0_dlast", bus.dcache_ret_last, 0);
    step();
    beat(4'd0, 32'hB0, 1'b1, 2'b00);
    settle();
    chk("t5_i_iret", bus.icache_ret_valid, 1);
    chk("t5_i_ilast", bus.icache_ret_last, 1);
    chk("t5_i_dret", bus.dcache_ret_valid, 0);
    chk("t5_i_data", bus.icache_ret_data, 32'hB0);
    for (int b = 1; b < 4; b++) begin
      step();
      beat(4'd1, 32'hA0 + b, (b == 3), 2'b00);
      settle();
      chk("t5_d_dret", bus.dcache_ret_valid, 1);
      chk("t5_d_dlast", bus.dcache_ret_last, (b == 3) ? 1 : 0);
      chk("t5_d_iret", bus.icache_ret_valid, 0);
    end
    step();
    r_idle();
    settle();
    chk("t5_rd_err", bus.rd_err, 0);

    // Stray beat for an idle ID: dropped and flagged; reset clears the flag
    step();
    beat(4'd1, 32'h99, 1'b1, 2'b00);
    settle();
    chk("t6_stray_dret", bus.dcache_ret_valid, 0);
    step();
    r_idle();
    settle();
    chk("t6_stray_err", bus.rd_err, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("t6_rst_err", bus.rd_err, 0);

    // Early rlast on beat 2 of 4: flagged, burst closed so icache can be granted again
    step();
    bus.icache_rd_req  = 1'b1;
    bus.icache_rd_type = 3'b100;
    bus.icache_rd_addr = 32'h9000;
    step();
    bus.icache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    step();
    bus.arready = 1'b0;
    beat(4'd0, 32'hC0, 1'b0, 2'b00);
    settle();
    chk("t6_b0_iret", bus.icache_ret_valid, 1);
    step();
    beat(4'd0, 32'hC1, 1'b1, 2'b00);
    settle();
    chk("t6_b1_ilast", bus.icache_ret_last, 1);
    step();
    r_idle();
    bus.icache_rd_req  = 1'b1;
    bus.icache_rd_type = 3'b010;
    bus.icache_rd_addr = 32'hA000;
    settle();
    chk("t6_short_err", bus.rd_err, 1);
    chk("t6_reopen_irdy", bus.icache_rd_rdy, 1);
    step();
    bus.icache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    step();
    bus.arready = 1'b0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("t6_rst2_err", bus.rd_err, 0);
    chk("t6_rst2_arv", bus.arvalid, 0);

    // Error response: beat still delivered, flag raised
    step();
    bus.icache_rd_req = 1'b1;
    settle();
    chk("t7_irdy", bus.icache_rd_rdy, 1);
    step();
    bus.icache_rd_req = 1'b0;
    bus.arready       = 1'b1;
    step();
    bus.arready = 1'b0;
    beat(4'd0, 32'h77, 1'b1, 2'b10);
    settle();
    chk("t7_iret", bus.icache_ret_valid, 1);
    chk("t7_idata", bus.icache_ret_data, 32'h77);
    step();
    r_idle();
    settle();
    chk("t7_resp_err", bus.rd_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
